// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds FSM encoding and the address legality check.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFS_BITS = $clog2(WORD_BYTES);
  localparam logic [31:0] ALIGN_MASK = 32'(WORD_BYTES - 1);

  // Misaligned or beyond the implemented word range.
  function automatic logic addr_bad(
    input logic [31:0] a,
    input int          aw
  );
    logic mis;
    logic oor;
    mis = (a & ALIGN_MASK) != 32'd0;
    oor = (a >> (aw + BYTE_OFS_BITS)) != 32'd0;
    return mis || oor;
  endfunction

endpackage

// File: rtl/dmem_array_1rw.sv
// Single-port word RAM: synchronous write, registered read.
// Only the read register is reset; the array keeps its contents.
module dmem_array_1rw #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// EU data-memory responder: request latch, wait-state FSM,
// error screening in front of a single-port word RAM.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] RAM_Address,
  input  logic [31:0] Data_to_RAM,
  output logic [31:0] Data_from_RAM,
  output logic        MemReady,
  output logic        MemError,
  output logic        Busy
);

  localparam logic [3:0] WLAST =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  mem_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic err_q, err_d;

  logic req;
  logic in_err;
  logic enter_resp;
  logic is_idle;
  logic cur_rd;
  logic cur_err;
  logic ram_we;
  logic ram_re;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic [ADDR_WIDTH-1:0] ram_idx;

  assign req    = MemRead || MemWrite;
  assign in_idx = RAM_Address[ADDR_WIDTH+1:2];
  assign in_err = addr_bad(RAM_Address, ADDR_WIDTH)
               || (MemRead && MemWrite);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (req) begin
          idx_d   = in_idx;
          wdata_d = Data_to_RAM;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          err_d   = in_err;
          cnt_d   = 4'd0;
          if (WAIT_STATES == 0) begin
            state_d    = MEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == WLAST) begin
          state_d    = MEM_RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Zero-wait reads must address the RAM straight from the inputs.
  assign is_idle = state_q == MEM_IDLE;
  assign cur_rd  = is_idle ? MemRead : rd_q;
  assign cur_err = is_idle ? in_err  : err_q;
  assign ram_idx = is_idle ? in_idx  : idx_q;

  assign ram_re = enter_resp && cur_rd && !cur_err && !reset;
  assign ram_we = (state_q == MEM_RESP) && wr_q && !err_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  dmem_array_1rw #(
    .AW(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (reset),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_idx),
    .wdata_i(wdata_q),
    .rdata_o(Data_from_RAM)
  );

  assign MemReady = state_q == MEM_RESP;
  assign MemError = MemReady && err_q;
  assign Busy     = !is_idle;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a 2-wait-state
// instance driven from a vector table, plus a 0-wait instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_rd, a_wr, a_rdy, a_err, a_busy;
  logic [31:0] a_addr, a_wd, a_dout;
  logic        b_reset, b_rd, b_wr, b_rdy, b_err, b_busy;
  logic [31:0] b_addr, b_wd, b_dout;

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(a_reset), .MemRead(a_rd), .MemWrite(a_wr),
    .RAM_Address(a_addr), .Data_to_RAM(a_wd),
    .Data_from_RAM(a_dout), .MemReady(a_rdy),
    .MemError(a_err), .Busy(a_busy)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(b_reset), .MemRead(b_rd), .MemWrite(b_wr),
    .RAM_Address(b_addr), .Data_to_RAM(b_wd),
    .Data_from_RAM(b_dout), .MemReady(b_rdy),
    .MemError(b_err), .Busy(b_busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] dout;
  } vec_t;

  vec_t vt[13];

  // One transaction on the 2-wait instance; lat = 0 on timeout.
  task automatic xact_a(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic err, output logic [31:0] dout,
                        output int lat);
    @(negedge clk);
    a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wd;
    lat = 0; err = 1'bx; dout = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_rdy) begin
        lat = i; err = a_err; dout = a_dout;
        break;
      end
    end
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        e;
    logic [31:0] d;
    int          lat;
    int          seen;

    vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b1, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF};
    vt[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
    vt[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h1111_1111};
    vt[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555, 1'b1, 32'h1111_1111};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
    vt[9]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0, 1'b0, 32'hA5A5_A5A5};
    vt[10] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 32'hA5A5_A5A5};
    vt[11] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_F00D};
    vt[12] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0BAD_F00D};

    a_reset = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wd = '0;
    b_reset = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wd = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_dout", a_dout, 32'h0);
    chk("rst_a_rdy",  32'(a_rdy),  32'h0);
    chk("rst_a_err",  32'(a_err),  32'h0);
    chk("rst_a_busy", 32'(a_busy), 32'h0);
    chk("rst_b_dout", b_dout, 32'h0);
    chk("rst_b_busy", 32'(b_busy), 32'h0);
    a_reset = 1'b0; b_reset = 1'b0;

    foreach (vt[i]) begin
      xact_a(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, e, d, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vt[i].err));
      chk($sformatf("v%0d_dout", i), d, vt[i].dout);
    end

    // Address changes during WAIT must not affect the read.
    @(negedge clk);
    a_rd = 1'b1; a_addr = 32'h10;
    @(negedge clk);
    chk("ign_busy", 32'(a_busy), 32'h1);
    a_addr = 32'h0;
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (a_rdy) begin
        lat = i;
        break;
      end
    end
    chk("ign_lat",  32'(lat), 32'd3);
    chk("ign_err",  32'(a_err), 32'h0);
    chk("ign_dout", a_dout, 32'hDEAD_BEEF);
    a_rd = 1'b0;

    // Reset during WAIT aborts a pending write.
    @(negedge clk);
    a_wr = 1'b1; a_addr = 32'h20; a_wd = 32'hCAFE_0001;
    @(negedge clk);
    chk("abort_busy_pre", 32'(a_busy), 32'h1);
    a_reset = 1'b1;
    @(negedge clk);
    chk("abort_rdy",  32'(a_rdy),  32'h0);
    chk("abort_err",  32'(a_err),  32'h0);
    chk("abort_busy", 32'(a_busy), 32'h0);
    chk("abort_dout", a_dout, 32'h0);
    a_reset = 1'b0; a_wr = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_rdy) seen++;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    xact_a(1'b1, 1'b0, 32'h20, 32'h0, e, d, lat);
    chk("abort_rd_lat",  32'(lat), 32'd3);
    chk("abort_rd_err",  32'(e), 32'h0);
    chk("abort_rd_dout", d, 32'h0BAD_F00D);

    // Reset wins over a same-cycle accept.
    @(negedge clk);
    a_reset = 1'b1; a_rd = 1'b1; a_addr = 32'h0;
    @(negedge clk);
    chk("rst_accept_busy", 32'(a_busy), 32'h0);
    a_reset = 1'b0; a_rd = 1'b0;
    @(negedge clk);
    chk("rst_accept_idle", 32'(a_busy), 32'h0);

    // Zero-wait instance: held request accepts every other cycle.
    @(negedge clk);
    b_wr = 1'b1; b_addr = 32'h8; b_wd = 32'h600D_CAFE;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("ws0_rdy%0d", i),  32'(b_rdy),  32'(i % 2));
      chk($sformatf("ws0_busy%0d", i), 32'(b_busy), 32'(i % 2));
    end
    chk("ws0_wr_err",  32'(b_err), 32'h0);
    chk("ws0_wr_dout", b_dout, 32'h0);
    b_wr = 1'b0;
    @(negedge clk);
    b_rd = 1'b1;
    @(negedge clk);
    chk("ws0_rd_rdy",  32'(b_rdy), 32'h1);
    chk("ws0_rd_err",  32'(b_err), 32'h0);
    chk("ws0_rd_dout", b_dout, 32'h600D_CAFE);
    b_rd = 1'b0;
    @(negedge clk);
    chk("ws0_idle", 32'(b_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the execution unit's RAM port. The EU drives RAM_Address and Data_to_RAM; this block answers with Data_from_RAM.
- Word-addressed synchronous RAM behind a request/ready handshake, with a configurable number of wait states.
- Lets the datapath be run against a memory that is slower than single-cycle.
- Flags misaligned, out-of-range and conflicting accesses instead of corrupting memory.

Parameters:
- ADDR_WIDTH, 8, word-address bits; depth = 2**ADDR_WIDTH 32-bit words (1 KiB by default).
- WAIT_STATES, 2, extra cycles between request accept and MemReady; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- MemRead  input  1  read request from control.
- MemWrite  input  1  write request from control.
- RAM_Address  input  32  byte address from the EU ALU result.
- Data_to_RAM  input  32  write data (EU ReadData2).
- Data_from_RAM  output  32  read data, registered.
- MemReady  output  1  one-cycle completion pulse.
- MemError  output  1  asserted with MemReady when the access was rejected.
- Busy  output  1  high while a request is in flight (states WAIT and RESP).

Behaviour:
- Reset, sampled on the clk edge:
  - state = IDLE; wait counter = 0.
  - Data_from_RAM = 0, MemReady = 0, MemError = 0, Busy = 0.
  - RAM contents are not cleared.
- States:
  - IDLE to WAIT on accept when WAIT_STATES > 0.
  - IDLE to RESP on accept when WAIT_STATES = 0.
  - WAIT to RESP when the counter reaches WAIT_STATES-1.
  - RESP to IDLE unconditionally.
- Accept:
  - Occurs in IDLE on a cycle where MemRead or MemWrite is high (accept cycle T).
  - Address, write data, and request type are latched at T.
  - Inputs are ignored while Busy; the requester holds its signals but they are not re-sampled.
- Latency: the RESP cycle is T + WAIT_STATES + 1. In that cycle MemReady = 1 for exactly one cycle, and MemError is valid.
- Writes: the word is written on the clk edge that ends RESP, only if there is no error.
- Reads:
  - Data_from_RAM is updated on the edge that enters RESP, so it is valid during the MemReady cycle.
  - It holds its value until the next successful read. Writes and errors do not change it.
- Back-to-back: a new request cannot be accepted in the RESP cycle. The earliest next accept is T + WAIT_STATES + 2.
- Errors, which set MemError = 1 in RESP, suppress any write and leave Data_from_RAM unchanged:
  - Misaligned: RAM_Address[1:0] != 0.
  - Out of range: RAM_Address[31:ADDR_WIDTH+2] != 0.
  - Conflict: MemRead and MemWrite both high at accept.
- Indexing: word index = RAM_Address[ADDR_WIDTH+1:2]. There is no wrap-around; out-of-range accesses are errors.
- Read after write to the same word in consecutive transactions returns the new data.
- Reset mid-transaction aborts it: no MemReady pulse, and a pending write is discarded.
- Reset and an accept in the same cycle: reset wins.

Decomposition:
- Shared package cpu_mem_pkg:
  - State encoding localparams: MEM_IDLE = 2'd0, MEM_WAIT = 2'd1, MEM_RESP = 2'd2.
  - Error-check helper constants.
  - WORD_BYTES = 4.
- Sub-module dmem_array_1rw: single-port synchronous word RAM (we, addr, wdata, rdata), with no reset on the array.
- The FSM, wait counter, latches and error check stay in data_mem_responder.

Test Plan:
- Write, then read:
  - With WAIT_STATES = 2: accept a MemWrite to 0x0000_0010 with data 0xDEAD_BEEF at cycle 5. Expect MemReady at cycle 8 with MemError = 0.
  - Then a MemRead of 0x10 accepted at cycle 9. Expect MemReady at cycle 12 with Data_from_RAM = 0xDEAD_BEEF.
- Misaligned read of 0x0000_0013:
  - Expect MemReady with MemError = 1.
  - Data_from_RAM keeps its previous value (0xDEAD_BEEF).
- Out-of-range write:
  - Write 0x0000_0400 with ADDR_WIDTH = 8, data 0x1234_5678. Expect MemError = 1.
  - A subsequent read of 0x0 returns the untouched prior value.
- Conflict and ignored inputs:
  - MemRead and MemWrite both high at accept: expect MemError = 1, and no change at the addressed word.
  - Changing RAM_Address during the WAIT cycles does not affect the result.
- Reset abort: accept a write of 0xCAFE_0001 to 0x20, then assert reset during WAIT.
  - All outputs go to 0 with no MemReady pulse.
  - A read of 0x20 returns the old contents.
- WAIT_STATES = 0 build:
  - Accept at T gives MemReady at T+1.
  - Requests held continuously give an accept every 2 cycles.
  - Busy is high exactly in the RESP cycles.
